// File: rtl/dds_inc_estimator.sv
// dds_inc_estimator: recovers the phase increment of an NCO/DDS from observed
// phase samples. Modular differences between consecutive accepted samples are
// summed over 2^WINDOW_LOG2 deltas. The window sum is the mean increment with
// WINDOW_LOG2 fractional bits. A sudden change in delta is flagged as a slip,
// and the window it falls in is thrown away.
module dds_inc_estimator #(
  parameter int PHASE_WIDTH = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int SLIP_TOL    = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               clear,
  input  logic [PHASE_WIDTH-1:0]             phase,
  output logic [PHASE_WIDTH+WINDOW_LOG2-1:0] inc_est,
  output logic                               est_valid,
  output logic                               slip
);

  localparam int SW = PHASE_WIDTH + WINDOW_LOG2;
  localparam logic [PHASE_WIDTH:0] SLIP_TOL_V = SLIP_TOL[PHASE_WIDTH:0];

  typedef enum logic {PRIME, ACCUM} state_t;

  state_t                 state_reg, state_next;
  logic [PHASE_WIDTH-1:0] prev_phase_reg, prev_phase_next;
  logic [PHASE_WIDTH-1:0] last_delta_reg, last_delta_next;
  logic [WINDOW_LOG2-1:0] count_reg, count_next;
  logic [SW-1:0]          sum_reg, sum_next;
  logic [SW-1:0]          inc_est_reg, inc_est_next;
  logic                   est_valid_reg, est_valid_next;
  logic                   slip_reg, slip_next;
  // Set once a delta has been accepted since the last restart or slip. It lets
  // the slip check continue across a normal window boundary, where count is 0.
  logic                   have_last_reg, have_last_next;

  logic [PHASE_WIDTH-1:0] delta;
  logic [PHASE_WIDTH:0]   diff;
  logic [PHASE_WIDTH:0]   abs_diff;
  logic                   is_slip;
  logic [SW-1:0]          sum_add;

  // Delta arithmetic and the slip decision for the sample currently presented
  always_comb begin
    delta    = phase - prev_phase_reg;
    diff     = {1'b0, delta} - {1'b0, last_delta_reg};
    abs_diff = diff[PHASE_WIDTH] ? (~diff + 1'b1) : diff;
    is_slip  = ((count_reg != '0) || have_last_reg) && (abs_diff > SLIP_TOL_V);
    sum_add  = sum_reg + {{WINDOW_LOG2{1'b0}}, delta};
  end

  // Next-state logic; pulse outputs default low every cycle
  always_comb begin
    state_next      = state_reg;
    prev_phase_next = prev_phase_reg;
    last_delta_next = last_delta_reg;
    count_next      = count_reg;
    sum_next        = sum_reg;
    inc_est_next    = inc_est_reg;
    have_last_next  = have_last_reg;
    est_valid_next  = 1'b0;
    slip_next       = 1'b0;
    if (clear) begin
      // clear beats enable; the estimate already reported is kept
      state_next      = PRIME;
      count_next      = '0;
      sum_next        = '0;
      last_delta_next = '0;
      have_last_next  = 1'b0;
    end else if (enable) begin
      case (state_reg)
        PRIME: begin
          prev_phase_next = phase;
          count_next      = '0;
          sum_next        = '0;
          have_last_next  = 1'b0;
          state_next      = ACCUM;
        end
        default: begin
          prev_phase_next = phase;
          last_delta_next = delta;
          if (is_slip) begin
            slip_next      = 1'b1;
            sum_next       = '0;
            count_next     = '0;
            have_last_next = 1'b0;
          end else begin
            have_last_next = 1'b1;
            if (count_reg == {WINDOW_LOG2{1'b1}}) begin
              inc_est_next   = sum_add;
              est_valid_next = 1'b1;
              sum_next       = '0;
              count_next     = '0;
            end else begin
              sum_next   = sum_add;
              count_next = count_reg + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= PRIME;
      prev_phase_reg <= '0;
      last_delta_reg <= '0;
      count_reg      <= '0;
      sum_reg        <= '0;
      inc_est_reg    <= '0;
      est_valid_reg  <= 1'b0;
      slip_reg       <= 1'b0;
      have_last_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_phase_reg <= prev_phase_next;
      last_delta_reg <= last_delta_next;
      count_reg      <= count_next;
      sum_reg        <= sum_next;
      inc_est_reg    <= inc_est_next;
      est_valid_reg  <= est_valid_next;
      slip_reg       <= slip_next;
      have_last_reg  <= have_last_next;
    end
  end

  assign inc_est   = inc_est_reg;
  assign est_valid = est_valid_reg;
  assign slip      = slip_reg;

endmodule

// File: tb/tb_dds_inc_estimator.sv
// Testbench for dds_inc_estimator. Stimulus pushes the expected slip and
// estimate events into a queue. A monitor pops an event and compares it
// whenever the DUT pulses est_valid or slip.
module tb_dds_inc_estimator;
  localparam int PW   = 8;
  localparam int WL   = 2;
  localparam int TOL  = 2;
  localparam int WIN  = 1 << WL;
  localparam int MASK = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [PW-1:0]     phase = '0;
  logic [PW+WL-1:0]  inc_est;
  logic              est_valid;
  logic              slip;

  dds_inc_estimator #(.PHASE_WIDTH(PW), .WINDOW_LOG2(WL), .SLIP_TOL(TOL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .phase(phase),
    .inc_est(inc_est), .est_valid(est_valid), .slip(slip)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_slip; int val; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: window of deltas kept as plain integers
  bit primed = 0;
  int prev_ph = 0, last_d = 0, win_sum = 0, win_n = 0, model_est = 0;
  bit have_last = 0;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_restart();
    primed = 0; win_sum = 0; win_n = 0; last_d = 0; have_last = 0;
  endtask

  task automatic model_accept(input int ph);
    int d;
    ev_t e;
    if (!primed) begin
      primed = 1; prev_ph = ph; win_sum = 0; win_n = 0; have_last = 0;
    end else begin
      d = (ph - prev_ph) & MASK;
      prev_ph = ph;
      if ((win_n != 0 || have_last) && ((d - last_d) > TOL || (last_d - d) > TOL)) begin
        e.is_slip = 1; e.val = 0; exp_q.push_back(e);
        win_sum = 0; win_n = 0; have_last = 0;
      end else begin
        have_last = 1;
        win_sum += d;
        win_n++;
        if (win_n == WIN) begin
          model_est = win_sum;
          e.is_slip = 0; e.val = win_sum; exp_q.push_back(e);
          win_sum = 0; win_n = 0;
        end
      end
      last_d = d;
    end
  endtask

  // One stimulus cycle, driven on the falling edge
  task automatic step(input bit en, input bit clr, input int ph);
    int p;
    p = ph & MASK;
    @(negedge clk);
    enable = en; clear = clr; phase = p[PW-1:0];
    if (clr) model_restart();
    else if (en) model_accept(p);
  endtask

  task automatic send(input int ph);
    step(1'b1, 1'b0, ph);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic drain(input string name);
    idle(2);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: sample just after each rising edge, pop on every DUT pulse
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (est_valid && slip) begin
          errors++;
          $display("FAIL pulse_overlap: est_valid=1 slip=1 required not both at %0t", $time);
        end
        if (est_valid || slip) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: est_valid=%0b slip=%0b with no event expected at %0t",
                     est_valid, slip, $time);
          end else begin
            e = exp_q.pop_front();
            chk("event_is_slip", int'(slip), int'(e.is_slip));
            if (!e.is_slip) chk("est_value", int'(inc_est), e.val);
          end
        end
        chk("inc_est_held", int'(inc_est), model_est);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int ph, base, r;
    repeat (3) @(negedge clk);
    chk("reset_inc_est", int'(inc_est), 0);
    chk("reset_est_valid", int'(est_valid), 0);
    chk("reset_slip", int'(slip), 0);
    @(negedge clk); reset = 1'b0;

    // Steady rate
    send(0); send(10); send(20); send(30); send(40);
    drain("steady");
    chk("steady_inc_est", int'(inc_est), 40);

    // Wrap-around and back-to-back windows
    step(1'b0, 1'b1, 0);
    send(250); send(4); send(14); send(24); send(34);
    send(44); send(54); send(64); send(74);
    drain("wrap");
    chk("wrap_inc_est", int'(inc_est), 40);

    // Fractional rate: deltas 10,11,10,11
    step(1'b0, 1'b1, 0);
    send(0); send(10); send(21); send(31); send(42);
    drain("frac");
    chk("frac_inc_est", int'(inc_est), 42);

    // Slip on delta 30, then a clean window
    step(1'b0, 1'b1, 0);
    send(0); send(10); send(20); send(50); send(60); send(70); send(80); send(90);
    drain("slip");
    chk("slip_inc_est", int'(inc_est), 40);

    // Delta changes of exactly 2 stay within tolerance
    step(1'b0, 1'b1, 0);
    send(0); send(10); send(22); send(32); send(44);
    drain("tol_edge");
    chk("tol_edge_inc_est", int'(inc_est), 44);

    // Enable gaps
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin send(i * 10); idle(3); end
    drain("gaps");
    chk("gaps_inc_est", int'(inc_est), 40);

    // Clear with a simultaneous enable: sample ignored, estimate retained
    send(0); send(10); send(20);
    step(1'b1, 1'b1, 30);
    idle(1);
    chk("clear_keeps_est", int'(inc_est), 40);
    send(100); send(105); send(110); send(115); send(120);
    drain("clear");
    chk("clear_reprime_est", int'(inc_est), 20);

    // Asynchronous reset between clock edges
    send(0); send(10); send(20);
    @(negedge clk); enable = 1'b0;
    #2 reset = 1'b1;
    model_restart(); model_est = 0; exp_q.delete();
    #1;
    chk("async_reset_inc_est", int'(inc_est), 0);
    chk("async_reset_est_valid", int'(est_valid), 0);
    chk("async_reset_slip", int'(slip), 0);
    @(negedge clk); reset = 1'b0;
    send(0); send(10); send(20); send(30);
    drain("post_reset_partial");
    send(40);
    drain("post_reset");
    chk("post_reset_inc_est", int'(inc_est), 40);

    // Randomized: drifting rate, occasional jumps, gaps and clears
    step(1'b0, 1'b1, 0);
    ph = $urandom_range(0, MASK);
    base = $urandom_range(1, MASK);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 199);
      if (r < 3) begin
        step($urandom_range(0, 1), 1'b1, ph);
        base = $urandom_range(1, MASK);
      end else if (r < 33) begin
        idle(1);
      end else begin
        r = $urandom_range(0, 19);
        if (r == 0) ph = ph + $urandom_range(0, MASK);
        else if (r < 6) ph = ph + base + $urandom_range(0, 6) - 3;
        else ph = ph + base;
        send(ph);
      end
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
